// File: rtl/q_max_argmax_pipe.sv
// Purpose: reduce NUM_ACT sign-magnitude Q-values to the maximum and its index.
// Latency: LAT = $clog2(NUM_ACT) cycles, one register per comparator-tree level.
// Backpressure: global stall, in_ready = ~out_valid | out_ready; all stages hold when low.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready      input handshake; in_q and in_mask sampled on transfer
//   in_q [NUM_ACT*Q_W]       packed Q-values, action k at in_q[k*Q_W +: Q_W]
//   in_mask [NUM_ACT]        1 = action legal (only with QMAX_MASK_EN)
//   out_valid / out_ready    output handshake; out_* held stable while stalled
//   out_q, out_idx, out_none maximum value, its index, no-legal-action flag
//
// Optional feature: define QMAX_MASK_EN to honour in_mask. Without it the mask
// is ignored, every action is legal and out_none is tied 0.
`timescale 1ns/1ps
module q_max_argmax_pipe #(
  parameter int Q_W = 16,
  parameter int NUM_ACT = 15,
  localparam int IDX_W = $clog2(NUM_ACT),
  localparam int LAT = $clog2(NUM_ACT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_ACT*Q_W-1:0] in_q,
  input  logic [NUM_ACT-1:0]     in_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [Q_W-1:0]         out_q,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_none
);

  // True when candidate b must replace a. Ties keep a, which always sits at the
  // lower index, so the lowest index wins among equals. A zero magnitude is
  // treated as non-negative so +0 and -0 compare equal.
  function automatic logic b_wins(input logic a_p, input logic [Q_W-1:0] a,
                                  input logic b_p, input logic [Q_W-1:0] b);
    logic a_neg;
    logic b_neg;
    a_neg = a[Q_W-1] & (|a[Q_W-2:0]);
    b_neg = b[Q_W-1] & (|b[Q_W-2:0]);
    if (!b_p) return 1'b0;
    if (!a_p) return 1'b1;
    if (a_neg != b_neg) return a_neg;
    if (!a_neg) return b[Q_W-2:0] > a[Q_W-2:0];
    return b[Q_W-2:0] < a[Q_W-2:0];
  endfunction

  logic           w_adv;
  logic [LAT-1:0] r_vld;

  assign w_adv     = ~r_vld[LAT-1] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[LAT-1];

  // Valid bits shift on every advance so bubbles move through too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld[0] <= in_valid;
      for (int l = 1; l < LAT; l++) r_vld[l] <= r_vld[l-1];
    end
  end

  // Leaf candidates. An illegal action carries value 0 / index 0 so that an
  // all-masked set naturally reduces to out_q=0, out_idx=0.
  logic [Q_W-1:0]   w_leaf_val [NUM_ACT];
  logic [IDX_W-1:0] w_leaf_idx [NUM_ACT];
  logic             w_leaf_prs [NUM_ACT];

  for (genvar k = 0; k < NUM_ACT; k++) begin : g_leaf
`ifdef QMAX_MASK_EN
    assign w_leaf_prs[k] = in_mask[k];
    assign w_leaf_val[k] = in_mask[k] ? in_q[k*Q_W +: Q_W] : '0;
    assign w_leaf_idx[k] = in_mask[k] ? IDX_W'(k) : '0;
`else
    assign w_leaf_prs[k] = 1'b1;
    assign w_leaf_val[k] = in_q[k*Q_W +: Q_W];
    assign w_leaf_idx[k] = IDX_W'(k);
`endif
  end

  for (genvar lv = 0; lv < LAT; lv++) begin : g_lvl
    localparam int N_IN  = (NUM_ACT + (1 << lv) - 1) >> lv;
    localparam int N_OUT = (N_IN + 1) / 2;
    localparam int N_PAD = 2 * N_OUT;

    logic [Q_W-1:0]   w_src_val [N_PAD];
    logic [IDX_W-1:0] w_src_idx [N_PAD];
    logic             w_src_prs [N_PAD];
    logic [Q_W-1:0]   w_nxt_val [N_OUT];
    logic [IDX_W-1:0] w_nxt_idx [N_OUT];
    logic             w_nxt_prs [N_OUT];
    logic [Q_W-1:0]   r_val [N_OUT];
    logic [IDX_W-1:0] r_idx [N_OUT];
    logic             r_prs [N_OUT];
    logic             w_ld;

    // Data only loads when a real set moves in, so out_* do not churn on bubbles.
    if (lv == 0) begin : g_ld0
      assign w_ld = w_adv & in_valid;
    end else begin : g_ldn
      assign w_ld = w_adv & r_vld[lv-1];
    end

    // An odd element count is padded with a non-present slot, so the last
    // element passes through unchanged.
    for (genvar k = 0; k < N_PAD; k++) begin : g_src
      if (k >= N_IN) begin : g_pad
        assign w_src_val[k] = '0;
        assign w_src_idx[k] = '0;
        assign w_src_prs[k] = 1'b0;
      end else if (lv == 0) begin : g_in
        assign w_src_val[k] = w_leaf_val[k];
        assign w_src_idx[k] = w_leaf_idx[k];
        assign w_src_prs[k] = w_leaf_prs[k];
      end else begin : g_prev
        assign w_src_val[k] = g_lvl[lv-1].r_val[k];
        assign w_src_idx[k] = g_lvl[lv-1].r_idx[k];
        assign w_src_prs[k] = g_lvl[lv-1].r_prs[k];
      end
    end

    always_comb begin
      for (int j = 0; j < N_OUT; j++) begin
        w_nxt_val[j] = w_src_val[2*j];
        w_nxt_idx[j] = w_src_idx[2*j];
        w_nxt_prs[j] = w_src_prs[2*j];
        if (b_wins(w_src_prs[2*j], w_src_val[2*j], w_src_prs[2*j+1], w_src_val[2*j+1])) begin
          w_nxt_val[j] = w_src_val[2*j+1];
          w_nxt_idx[j] = w_src_idx[2*j+1];
          w_nxt_prs[j] = w_src_prs[2*j+1];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j < N_OUT; j++) begin
          r_val[j] <= '0;
          r_idx[j] <= '0;
          r_prs[j] <= 1'b0;
        end
      end else if (w_ld) begin
        for (int j = 0; j < N_OUT; j++) begin
          r_val[j] <= w_nxt_val[j];
          r_idx[j] <= w_nxt_idx[j];
          r_prs[j] <= w_nxt_prs[j];
        end
      end
    end
  end

  assign out_q   = g_lvl[LAT-1].r_val[0];
  assign out_idx = g_lvl[LAT-1].r_idx[0];
`ifdef QMAX_MASK_EN
  assign out_none = ~g_lvl[LAT-1].r_prs[0];
`else
  assign out_none = 1'b0;
`endif

endmodule

// File: tb/tb_q_max_argmax_pipe.sv
`timescale 1ns/1ps
module tb_q_max_argmax_pipe;
  localparam int QW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-action instance
  logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_none;
  logic [4*QW-1:0] a_in_q;
  logic [3:0]      a_in_mask;
  logic [QW-1:0]   a_out_q;
  logic [1:0]      a_out_idx;
  // 15-action instance
  logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_none;
  logic [15*QW-1:0] b_in_q;
  logic [14:0]      b_in_mask;
  logic [QW-1:0]    b_out_q;
  logic [3:0]       b_out_idx;

  q_max_argmax_pipe #(.Q_W(QW), .NUM_ACT(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_q(a_in_q), .in_mask(a_in_mask), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_q(a_out_q), .out_idx(a_out_idx), .out_none(a_out_none));

  q_max_argmax_pipe #(.Q_W(QW), .NUM_ACT(15)) u_dut15 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_q(b_in_q), .in_mask(b_in_mask), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_q(b_out_q), .out_idx(b_out_idx), .out_none(b_out_none));

  typedef struct { logic [QW-1:0] q; logic [3:0] idx; logic none; } exp_t;
  typedef struct { logic [4*QW-1:0] q; logic [3:0] m; logic [QW-1:0] eq; logic [3:0] ei; logic en; } vec_t;

  exp_t a_sb[$];
  exp_t b_sb[$];
  vec_t tab[8];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // Reference: signed interpretation of sign-magnitude, strict > keeps lowest index.
  function automatic exp_t ref_max(input logic [15*QW-1:0] q, input logic [14:0] m, input int n);
    exp_t e;
    int best, v;
    logic found, legal;
    logic [QW-1:0] x;
    found = 1'b0; best = 0;
    e.q = '0; e.idx = '0; e.none = 1'b1;
    for (int k = 0; k < n; k++) begin
      x = q[k*QW +: QW];
      v = x[QW-1] ? -int'(x[QW-2:0]) : int'(x[QW-2:0]);
      legal = 1'b1;
`ifdef QMAX_MASK_EN
      legal = m[k];
`endif
      if (legal && (!found || v > best)) begin
        found = 1'b1; best = v; e.q = x; e.idx = 4'(k); e.none = 1'b0;
      end
    end
    return e;
  endfunction

  function automatic logic [QW-1:0] rand_val();
    logic [QW-1:0] v;
    v[QW-1] = 1'($urandom_range(0, 1));
    v[QW-2:0] = ($urandom_range(0, 9) == 0) ? 15'($urandom) : 15'($urandom_range(0, 6));
    return v;
  endfunction

  // Output monitors: scoreboard compare, hold stability and stall checks.
  logic a_hold = 1'b0, b_hold = 1'b0;
  logic [QW-1:0] a_hq, b_hq;
  logic [3:0] a_hi, b_hi;
  exp_t a_e, b_e;

  always @(negedge clk) begin
    if (rst) begin
      a_hold = 1'b0;
    end else begin
      if (a_hold) begin
        chk("A hold valid", a_out_valid, 1);
        chk("A hold q", a_out_q, a_hq);
        chk("A hold idx", a_out_idx, a_hi);
      end
      if (a_out_valid && !a_out_ready) chk("A stall in_ready", a_in_ready, 0);
      if (a_out_valid && a_out_ready) begin
        if (a_sb.size() == 0) flag("A unexpected output");
        else begin
          a_e = a_sb.pop_front();
          chk("A out_q", a_out_q, a_e.q);
          chk("A out_idx", a_out_idx, a_e.idx);
          chk("A out_none", a_out_none, a_e.none);
        end
      end
      a_hold = a_out_valid && !a_out_ready;
      a_hq = a_out_q; a_hi = 4'(a_out_idx);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      b_hold = 1'b0;
    end else begin
      if (b_hold) begin
        chk("B hold valid", b_out_valid, 1);
        chk("B hold q", b_out_q, b_hq);
        chk("B hold idx", b_out_idx, b_hi);
      end
      if (b_out_valid && !b_out_ready) chk("B stall in_ready", b_in_ready, 0);
      if (b_out_valid && b_out_ready) begin
        if (b_sb.size() == 0) flag("B unexpected output");
        else begin
          b_e = b_sb.pop_front();
          chk("B out_q", b_out_q, b_e.q);
          chk("B out_idx", b_out_idx, b_e.idx);
          chk("B out_none", b_out_none, b_e.none);
        end
      end
      b_hold = b_out_valid && !b_out_ready;
      b_hq = b_out_q; b_hi = b_out_idx;
    end
  end

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send_a(input logic [4*QW-1:0] q, input logic [3:0] m, input exp_t e);
    int n = 0;
    a_in_valid = 1'b1; a_in_q = q; a_in_mask = m;
    do begin @(negedge clk); n++; end while (!a_in_ready && n < 100);
    if (!a_in_ready) flag("A send timeout");
    a_sb.push_back(e);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [15*QW-1:0] q, input logic [14:0] m, input exp_t e);
    int n = 0;
    b_in_valid = 1'b1; b_in_q = q; b_in_mask = m;
    do begin @(negedge clk); n++; end while (!b_in_ready && n < 100);
    if (!b_in_ready) flag("B send timeout");
    b_sb.push_back(e);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((a_sb.size() != 0 || b_sb.size() != 0) && n < 300) begin @(posedge clk); n++; end
    if (a_sb.size() != 0 || b_sb.size() != 0) flag("drain timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [15*QW-1:0] bq;
    logic [4*QW-1:0] aq;
    logic [3:0] am;

    tab[0] = '{q:{16'h0001,16'h0009,16'h0009,16'h0003}, m:4'hF, eq:16'h0009, ei:4'd1, en:1'b0};
    tab[1] = '{q:{16'h8010,16'h8007,16'h8002,16'h8005}, m:4'hF, eq:16'h8002, ei:4'd1, en:1'b0};
    tab[2] = '{q:{16'h8001,16'h8003,16'h0000,16'h8000}, m:4'hF, eq:16'h8000, ei:4'd0, en:1'b0};
    tab[3] = '{q:{16'h0001,16'h7FFF,16'h8001,16'hFFFF}, m:4'hF, eq:16'h7FFF, ei:4'd2, en:1'b0};
    tab[4] = '{q:{16'h0005,16'h0005,16'h0005,16'h0005}, m:4'hF, eq:16'h0005, ei:4'd0, en:1'b0};
    tab[5] = '{q:{16'h0004,16'h0003,16'h0002,16'h0001}, m:4'hF, eq:16'h0004, ei:4'd3, en:1'b0};
`ifdef QMAX_MASK_EN
    tab[6] = '{q:{16'h0004,16'h8002,16'h0001,16'h0009}, m:4'b1010, eq:16'h0004, ei:4'd3, en:1'b0};
    tab[7] = '{q:{16'h0004,16'h8002,16'h0001,16'h0009}, m:4'b0000, eq:16'h0000, ei:4'd0, en:1'b1};
`else
    tab[6] = '{q:{16'h0004,16'h8002,16'h0001,16'h0009}, m:4'b1010, eq:16'h0009, ei:4'd0, en:1'b0};
    tab[7] = '{q:{16'h0004,16'h8002,16'h0001,16'h0009}, m:4'b0000, eq:16'h0009, ei:4'd0, en:1'b0};
`endif

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_q = '0; a_in_mask = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_q = '0; b_in_mask = '0; b_out_ready = 1'b1;
    #7;
    chk("rst A out_valid", a_out_valid, 0);
    chk("rst A out_q", a_out_q, 0);
    chk("rst A out_idx", a_out_idx, 0);
    chk("rst A out_none", a_out_none, 0);
    chk("rst B out_valid", b_out_valid, 0);
    chk("rst B out_q", b_out_q, 0);
    #5 rst = 1'b0;
    @(negedge clk);
    chk("post-rst A in_ready", a_in_ready, 1);
    chk("post-rst B in_ready", b_in_ready, 1);
    @(posedge clk); #1;

    // T1 with exact latency of 2
    send_a(tab[0].q, tab[0].m, '{q:tab[0].eq, idx:tab[0].ei, none:tab[0].en});
    for (int k = 1; k <= 2; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      chk($sformatf("T1 out_valid cycle %0d", k), a_out_valid, (k == 2) ? 1 : 0);
    end
    drain();

    // T3: only action 14 positive, latency 4
    for (int k = 0; k < 15; k++) bq[k*QW +: QW] = (k == 14) ? 16'h0001 : 16'h8001;
    send_b(bq, 15'h7FFF, '{q:16'h0001, idx:4'd14, none:1'b0});
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      chk($sformatf("T3 out_valid cycle %0d", k), b_out_valid, (k == 4) ? 1 : 0);
    end
    drain();

    // Table vectors, back-to-back
    for (int i = 0; i < 8; i++)
      send_a(tab[i].q, tab[i].m, '{q:tab[i].eq, idx:tab[i].ei, none:tab[i].en});
    drain();

    // T4: 8 back-to-back sets with a 3-cycle output stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          for (int k = 0; k < 15; k++) bq[k*QW +: QW] = rand_val();
          send_b(bq, 15'h7FFF, ref_max(bq, 15'h7FFF, 15));
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 b_out_ready = 1'b1;
      end
    join
    drain();

    // Random stream with random masks and random out_ready
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          for (int k = 0; k < 4; k++) aq[k*QW +: QW] = rand_val();
          am = 4'($urandom_range(0, 15));
          send_a(aq, am, ref_max((15*QW)'(aq), 15'(am), 4));
        end
      end
      begin
        repeat (40) begin @(posedge clk); #1 a_out_ready = 1'($urandom_range(0, 1)); end
        a_out_ready = 1'b1;
      end
    join
    drain();

    // T5: reset with two sets in flight
    a_out_ready = 1'b0;
    send_a(tab[1].q, 4'hF, '{q:16'h8002, idx:4'd1, none:1'b0});
    send_a(tab[5].q, 4'hF, '{q:16'h0004, idx:4'd3, none:1'b0});
    chk("T5 out_valid before reset", a_out_valid, 1);
    #3 rst = 1'b1;
    #1;
    chk("T5 out_valid drops", a_out_valid, 0);
    chk("T5 out_q cleared", a_out_q, 0);
    a_sb.delete();
    b_sb.delete();
    a_out_ready = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("T5 idle out_valid %0d", k), a_out_valid, 0);
    end
    @(posedge clk); #1;
    send_a(tab[3].q, 4'hF, '{q:16'h7FFF, idx:4'd2, none:1'b0});
    drain();

    chk("A scoreboard empty", a_sb.size(), 0);
    chk("B scoreboard empty", b_sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
